r2w_ptr_sync_status: RTL and testbench
======================================

Name: r2w_ptr_sync_status

Overview:
- Parametrised successor of the two-flop read-to-write pointer synchroniser used in the async FIFO.
- Brings the Gray-coded read pointer into the write-clock domain through a configurable number of flop stages.
- Converts the synchronised pointer to binary and produces registered write-side status: occupancy, full, almost-full and a warm-up valid.
- Sits in the write domain between the read-pointer logic and the write controller.

Parameters:
- ADDR_WIDTH, 8, FIFO address width; pointers are ADDR_WIDTH+1 bits; DEPTH = 2**ADDR_WIDTH.
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4; values outside this range are rejected at elaboration.

Ports:
- wrclk  in  1  write-domain clock.
- wr_rst  in  1  reset, asynchronous, active-high.
- rptr_gray  in  ADDR_WIDTH+1  read pointer, Gray-coded, from the read domain.
- wptr_bin  in  ADDR_WIDTH+1  local write pointer, binary, write domain.
- afull_level  in  ADDR_WIDTH+1  almost-full threshold; quasi-static.
- rptr_sync  out  ADDR_WIDTH+1  synchronised Gray read pointer (last sync stage).
- rptr_sync_bin  out  ADDR_WIDTH+1  binary conversion of rptr_sync; combinational from the last stage.
- wr_count  out  ADDR_WIDTH+1  registered occupancy as seen by the write side.
- wr_full  out  1  registered full flag.
- wr_afull  out  1  registered almost-full flag.
- sync_valid  out  1  high once the sync chain holds post-reset data.
- sync_err  out  1  sticky Gray/overflow error; tied 0 when the optional feature is compiled out.

Behaviour:
- Interface:
  - One clock, wrclk.
  - Reset wr_rst is asynchronous and active-high.
  - All flops clear on assertion without waiting for a clock edge.
- Reset values:
  - Sync stages = 0, rptr_sync = 0, rptr_sync_bin = 0.
  - wr_count = 0, wr_afull = 0, sync_valid = 0, sync_err = 0.
  - wr_full = 1, so the FIFO is write-blocked during reset.
- Sync chain:
  - Stage[0] <= rptr_gray; stage[i] <= stage[i-1].
  - rptr_sync = stage[SYNC_STAGES-1].
  - Latency: a change on rptr_gray appears on rptr_sync after exactly SYNC_STAGES rising edges of wrclk.
- Gray to binary: bin[MSB] = gray[MSB]; bin[i] = bin[i+1] ^ gray[i].
- Warm-up counter:
  - Counts 0..SYNC_STAGES starting on the first edge after reset deassertion.
  - sync_valid goes to 1 when the count reaches SYNC_STAGES, then holds (saturates).
  - While sync_valid = 0, wr_full is forced to 1, wr_afull = 0 and wr_count = 0.
- Status, registered one cycle after its inputs:
  - diff = (wptr_bin - rptr_sync_bin) modulo 2**(ADDR_WIDTH+1); wrap-around of either pointer is handled by this modular arithmetic.
  - wr_count <= diff.
  - wr_full <= (diff >= DEPTH).
  - wr_afull <= (diff >= afull_level).
  - Latency is 1 cycle from wptr_bin and SYNC_STAGES+1 cycles from rptr_gray.
- Boundaries:
  - diff == DEPTH: full.
  - diff > DEPTH is illegal; it still reports full and wr_count = diff.
  - afull_level = 0 makes wr_afull = 1 whenever sync_valid = 1.
  - afull_level > DEPTH makes wr_afull never assert.
  - A pointer update on both inputs in the same cycle is evaluated as one combined step; there is no ordering between them.
- Reset mid-operation: every output returns to its reset value immediately, and the warm-up sequence restarts after deassertion.

Optional Feature:
- Macro: SYNC_GRAY_CHK_EN.
- Defined:
  - A register holds the previous rptr_sync.
  - If more than one bit differs between consecutive rptr_sync values, or diff > DEPTH while sync_valid = 1, sync_err is set on the next edge.
  - sync_err is sticky until wr_rst.
  - Checking is suppressed while sync_valid = 0.
- Undefined: no checker logic is built; sync_err is driven constant 0 and the port remains present.

Test Plan:
All scenarios use ADDR_WIDTH=3 (DEPTH 8) and SYNC_STAGES=2.
1. Reset release:
   - Hold wr_rst=1, then deassert with rptr_gray=0, wptr_bin=0.
   - Required: wr_full=1 until sync_valid rises on the 2nd edge; the following edge gives wr_full=0, wr_count=0.
2. Latency:
   - After warm-up, set rptr_gray 0000→0001 with wptr_bin=5.
   - Required: rptr_sync=0001 and rptr_sync_bin=1 after 2 edges; wr_count=4 on the 3rd edge.
3. Full / almost-full:
   - Set rptr_gray=0 and afull_level=6.
   - wptr_bin=6 → wr_afull=1, wr_full=0.
   - wptr_bin=8 → wr_count=8, wr_full=1.
4. Wrap-around:
   - Set rptr_gray=1001 (binary 14) and wptr_bin=2.
   - Required: wr_count=4, wr_full=0.
5. Gray error (SYNC_GRAY_CHK_EN defined):
   - Step rptr_gray 0000→0011.
   - Required: sync_err=1 three edges later; it stays 1 after rptr_gray returns to legal steps, and clears only on wr_rst.
6. Async reset mid-operation:
   - With wr_count=5, pulse wr_rst between clock edges.
   - Required: wr_count=0, wr_full=1, sync_valid=0 immediately without a clock edge; the warm-up sequence repeats after release.

Source files
------------

// File: rtl/r2w_ptr_sync_status.sv
// Read-to-write Gray pointer synchroniser with registered write-side occupancy/full/almost-full status.
// Define SYNC_GRAY_CHK_EN to build the sticky Gray-step / overflow checker driving sync_err.
module r2w_ptr_sync_status #(
   parameter int ADDR_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                wrclk,
   input  logic                wr_rst,
   input  logic [ADDR_WIDTH:0] rptr_gray,
   input  logic [ADDR_WIDTH:0] wptr_bin,
   input  logic [ADDR_WIDTH:0] afull_level,
   output logic [ADDR_WIDTH:0] rptr_sync,
   output logic [ADDR_WIDTH:0] rptr_sync_bin,
   output logic [ADDR_WIDTH:0] wr_count,
   output logic                wr_full,
   output logic                wr_afull,
   output logic                sync_valid,
   output logic                sync_err
);

   localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [2:0]          WARM_MAX = 3'(SYNC_STAGES);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
         $error("r2w_ptr_sync_status: SYNC_STAGES must be in 2..4");
      end
   endgenerate

   // Stage 0 is the metastability-catching flop; only the last stage is used downstream.
   logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] sync_q;

   // NOTE: the sync chain is a handful of flops, not a memory, so it is reset with the rest of the state.
   always_ff @(posedge wrclk or posedge wr_rst) begin
      if (wr_rst) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignment makes every stage sample the pre-edge value of its predecessor.
         sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray};
      end
   end

   assign rptr_sync = sync_q[SYNC_STAGES-1];

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rptr_sync_bin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         rptr_sync_bin[i] = ^(rptr_sync >> i);
      end
   end

   logic [2:0] warm_cnt;

   always_ff @(posedge wrclk or posedge wr_rst) begin
      if (wr_rst) begin
         warm_cnt <= '0;
      end else if (warm_cnt != WARM_MAX) begin
         warm_cnt <= warm_cnt + 3'd1;
      end
   end

   assign sync_valid = (warm_cnt == WARM_MAX);

   // Modular subtraction absorbs pointer wrap-around on either side.
   logic [ADDR_WIDTH:0] diff;
   assign diff = wptr_bin - rptr_sync_bin;

   always_ff @(posedge wrclk or posedge wr_rst) begin
      if (wr_rst) begin
         wr_count <= '0;
         wr_full  <= 1'b1;
         wr_afull <= 1'b0;
      end else if (!sync_valid) begin
         // Chain still holds reset zeros: keep writers blocked until it is trustworthy.
         wr_count <= '0;
         wr_full  <= 1'b1;
         wr_afull <= 1'b0;
      end else begin
         wr_count <= diff;
         wr_full  <= (diff >= DEPTH);
         wr_afull <= (diff >= afull_level);
      end
   end

`ifdef SYNC_GRAY_CHK_EN
   logic [ADDR_WIDTH:0] rptr_prev;
   logic                multi_step;
   logic                overflow;

   assign multi_step = ($countones(rptr_sync ^ rptr_prev) > 1);
   assign overflow   = (diff > DEPTH);

   always_ff @(posedge wrclk or posedge wr_rst) begin
      if (wr_rst) begin
         rptr_prev <= '0;
         sync_err  <= 1'b0;
      end else begin
         rptr_prev <= rptr_sync;
         if (sync_valid && (multi_step || overflow)) begin
            sync_err <= 1'b1;
         end
      end
   end
`else
   assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_r2w_ptr_sync_status.sv
// Directed bench for r2w_ptr_sync_status with ADDR_WIDTH=3 (DEPTH 8), SYNC_STAGES=2.
// Expected sync_err follows SYNC_GRAY_CHK_EN when the bench is compiled with the same macro.
module tb_r2w_ptr_sync_status;

   logic       wrclk = 1'b0;
   logic       wr_rst;
   logic [3:0] rptr_gray;
   logic [3:0] wptr_bin;
   logic [3:0] afull_level;
   logic [3:0] rptr_sync;
   logic [3:0] rptr_sync_bin;
   logic [3:0] wr_count;
   logic       wr_full;
   logic       wr_afull;
   logic       sync_valid;
   logic       sync_err;

   int n_cmp = 0;
   int n_mis = 0;

   r2w_ptr_sync_status #(.ADDR_WIDTH(3), .SYNC_STAGES(2)) dut (
      .wrclk         (wrclk),
      .wr_rst        (wr_rst),
      .rptr_gray     (rptr_gray),
      .wptr_bin      (wptr_bin),
      .afull_level   (afull_level),
      .rptr_sync     (rptr_sync),
      .rptr_sync_bin (rptr_sync_bin),
      .wr_count      (wr_count),
      .wr_full       (wr_full),
      .wr_afull      (wr_afull),
      .sync_valid    (sync_valid),
      .sync_err      (sync_err)
   );

   always #5 wrclk = ~wrclk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge wrclk);
         #1;
      end
   endtask

   task automatic test_reset;
      wr_rst = 1'b1; rptr_gray = 4'd0; wptr_bin = 4'd0; afull_level = 4'd6;
      tick(2);
      n_cmp++; if (wr_full !== 1'b1)     begin n_mis++; $display("FAIL rst_full: got %0b want 1", wr_full); end
      n_cmp++; if (wr_count !== 4'd0)    begin n_mis++; $display("FAIL rst_count: got %0d want 0", wr_count); end
      n_cmp++; if (wr_afull !== 1'b0)    begin n_mis++; $display("FAIL rst_afull: got %0b want 0", wr_afull); end
      n_cmp++; if (sync_valid !== 1'b0)  begin n_mis++; $display("FAIL rst_valid: got %0b want 0", sync_valid); end
      n_cmp++; if (rptr_sync !== 4'd0)   begin n_mis++; $display("FAIL rst_sync: got %0d want 0", rptr_sync); end
      n_cmp++; if (sync_err !== 1'b0)    begin n_mis++; $display("FAIL rst_err: got %0b want 0", sync_err); end
      wr_rst = 1'b0;
      tick(1);
      n_cmp++; if (sync_valid !== 1'b0)  begin n_mis++; $display("FAIL warm1_valid: got %0b want 0", sync_valid); end
      n_cmp++; if (wr_full !== 1'b1)     begin n_mis++; $display("FAIL warm1_full: got %0b want 1", wr_full); end
      tick(1);
      n_cmp++; if (sync_valid !== 1'b1)  begin n_mis++; $display("FAIL warm2_valid: got %0b want 1", sync_valid); end
      n_cmp++; if (wr_full !== 1'b1)     begin n_mis++; $display("FAIL warm2_full: got %0b want 1", wr_full); end
      tick(1);
      n_cmp++; if (wr_full !== 1'b0)     begin n_mis++; $display("FAIL warm3_full: got %0b want 0", wr_full); end
      n_cmp++; if (wr_count !== 4'd0)    begin n_mis++; $display("FAIL warm3_count: got %0d want 0", wr_count); end
   endtask

   task automatic test_latency;
      rptr_gray = 4'b0001; wptr_bin = 4'd5;
      tick(1);
      n_cmp++; if (rptr_sync !== 4'd0)     begin n_mis++; $display("FAIL lat1_sync: got %0d want 0", rptr_sync); end
      tick(1);
      n_cmp++; if (rptr_sync !== 4'b0001)  begin n_mis++; $display("FAIL lat2_sync: got %0d want 1", rptr_sync); end
      n_cmp++; if (rptr_sync_bin !== 4'd1) begin n_mis++; $display("FAIL lat2_bin: got %0d want 1", rptr_sync_bin); end
      n_cmp++; if (wr_count !== 4'd5)      begin n_mis++; $display("FAIL lat2_count: got %0d want 5", wr_count); end
      tick(1);
      n_cmp++; if (wr_count !== 4'd4)      begin n_mis++; $display("FAIL lat3_count: got %0d want 4", wr_count); end
      n_cmp++; if (wr_full !== 1'b0)       begin n_mis++; $display("FAIL lat3_full: got %0b want 0", wr_full); end
   endtask

   task automatic test_full_afull;
      rptr_gray = 4'd0; wptr_bin = 4'd6; afull_level = 4'd6;
      tick(3);
      n_cmp++; if (wr_count !== 4'd6) begin n_mis++; $display("FAIL af6_count: got %0d want 6", wr_count); end
      n_cmp++; if (wr_afull !== 1'b1) begin n_mis++; $display("FAIL af6_afull: got %0b want 1", wr_afull); end
      n_cmp++; if (wr_full !== 1'b0)  begin n_mis++; $display("FAIL af6_full: got %0b want 0", wr_full); end
      wptr_bin = 4'd8;
      tick(1);
      n_cmp++; if (wr_count !== 4'd8) begin n_mis++; $display("FAIL f8_count: got %0d want 8", wr_count); end
      n_cmp++; if (wr_full !== 1'b1)  begin n_mis++; $display("FAIL f8_full: got %0b want 1", wr_full); end
      wptr_bin = 4'd9;
      tick(1);
      n_cmp++; if (wr_count !== 4'd9) begin n_mis++; $display("FAIL f9_count: got %0d want 9", wr_count); end
      n_cmp++; if (wr_full !== 1'b1)  begin n_mis++; $display("FAIL f9_full: got %0b want 1", wr_full); end
      wptr_bin = 4'd7;
      tick(1);
      n_cmp++; if (wr_full !== 1'b0)  begin n_mis++; $display("FAIL f7_full: got %0b want 0", wr_full); end
      n_cmp++; if (wr_afull !== 1'b1) begin n_mis++; $display("FAIL f7_afull: got %0b want 1", wr_afull); end
      afull_level = 4'd0; wptr_bin = 4'd0;
      tick(1);
      n_cmp++; if (wr_afull !== 1'b1) begin n_mis++; $display("FAIL lvl0_afull: got %0b want 1", wr_afull); end
      n_cmp++; if (wr_full !== 1'b0)  begin n_mis++; $display("FAIL lvl0_full: got %0b want 0", wr_full); end
      afull_level = 4'd9; wptr_bin = 4'd8;
      tick(1);
      n_cmp++; if (wr_afull !== 1'b0) begin n_mis++; $display("FAIL lvl9_afull: got %0b want 0", wr_afull); end
      n_cmp++; if (wr_full !== 1'b1)  begin n_mis++; $display("FAIL lvl9_full: got %0b want 1", wr_full); end
      afull_level = 4'd6;
   endtask

   task automatic test_wrap;
      rptr_gray = 4'b1001; wptr_bin = 4'd2;
      tick(3);
      n_cmp++; if (rptr_sync_bin !== 4'd14) begin n_mis++; $display("FAIL wrap_bin: got %0d want 14", rptr_sync_bin); end
      n_cmp++; if (wr_count !== 4'd4)       begin n_mis++; $display("FAIL wrap_count: got %0d want 4", wr_count); end
      n_cmp++; if (wr_full !== 1'b0)        begin n_mis++; $display("FAIL wrap_full: got %0b want 0", wr_full); end
   endtask

   task automatic test_async_reset;
      rptr_gray = 4'd0; wptr_bin = 4'd5;
      tick(3);
      n_cmp++; if (wr_count !== 4'd5)   begin n_mis++; $display("FAIL ar_pre_count: got %0d want 5", wr_count); end
      #2 wr_rst = 1'b1;
      #1;
      n_cmp++; if (wr_count !== 4'd0)   begin n_mis++; $display("FAIL ar_count: got %0d want 0", wr_count); end
      n_cmp++; if (wr_full !== 1'b1)    begin n_mis++; $display("FAIL ar_full: got %0b want 1", wr_full); end
      n_cmp++; if (sync_valid !== 1'b0) begin n_mis++; $display("FAIL ar_valid: got %0b want 0", sync_valid); end
      n_cmp++; if (sync_err !== 1'b0)   begin n_mis++; $display("FAIL ar_err: got %0b want 0", sync_err); end
      #1 wr_rst = 1'b0;
      tick(1);
      n_cmp++; if (sync_valid !== 1'b0) begin n_mis++; $display("FAIL ar_w1_valid: got %0b want 0", sync_valid); end
      tick(1);
      n_cmp++; if (sync_valid !== 1'b1) begin n_mis++; $display("FAIL ar_w2_valid: got %0b want 1", sync_valid); end
      n_cmp++; if (wr_full !== 1'b1)    begin n_mis++; $display("FAIL ar_w2_full: got %0b want 1", wr_full); end
      tick(1);
      n_cmp++; if (wr_full !== 1'b0)    begin n_mis++; $display("FAIL ar_w3_full: got %0b want 0", wr_full); end
      n_cmp++; if (wr_count !== 4'd5)   begin n_mis++; $display("FAIL ar_w3_count: got %0d want 5", wr_count); end
   endtask

   task automatic test_gray_err;
      logic exp_err;
`ifdef SYNC_GRAY_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      n_cmp++; if (sync_err !== 1'b0)    begin n_mis++; $display("FAIL ge_pre: got %0b want 0", sync_err); end
      rptr_gray = 4'b0011;
      tick(2);
      n_cmp++; if (sync_err !== 1'b0)    begin n_mis++; $display("FAIL ge_e2: got %0b want 0", sync_err); end
      tick(1);
      n_cmp++; if (sync_err !== exp_err) begin n_mis++; $display("FAIL ge_e3: got %0b want %0b", sync_err, exp_err); end
      rptr_gray = 4'b0010;
      tick(3);
      rptr_gray = 4'b0110;
      tick(3);
      n_cmp++; if (sync_err !== exp_err) begin n_mis++; $display("FAIL ge_sticky: got %0b want %0b", sync_err, exp_err); end
      #2 wr_rst = 1'b1;
      #1;
      n_cmp++; if (sync_err !== 1'b0)    begin n_mis++; $display("FAIL ge_clr: got %0b want 0", sync_err); end
      #1 wr_rst = 1'b0;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_full_afull();
      test_wrap();
      test_async_reset();
      test_gray_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
